rle_key_player: RTL and testbench

Synthesizable playback engine for recorded buzzer tracks. Reads run-length entries `{key, count}` from a synchronous on-chip RAM and expands them into a per-cycle ASCII key stream for the buzzer/note path. A one-cycle `tick` paces the playback. It is the read-side counterpart of the recorder, which writes the same entry format into the same RAM.

---
 rtl/rle_key_player.sv | 184 ++++++++++++++++++
 tb/tb_rle_key_player.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_key_player.sv
// Run-length playback engine: fetches {key, count} entries from a synchronous RAM and
// expands them into a ticked key stream. Optional replay controlled by RLE_PLAYER_LOOP_EN.
module rle_key_player #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned KEY_W  = 7,
    parameter int unsigned CNT_W  = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDR_W:0]          num_entries,
    input  logic                     tick,
`ifdef RLE_PLAYER_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [KEY_W+CNT_W-1:0]   mem_rd_data,
    output logic [KEY_W-1:0]         newkey,
    output logic                     key_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_PLAY
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fin_q, fin_d;
    logic [KEY_W-1:0]   newkey_q, newkey_d;
    logic               key_valid_q, key_valid_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   idx_inc;
    logic [KEY_W-1:0]   rd_key;
    logic [CNT_W-1:0]   rd_cnt;
    logic               loop_c;
    logic               adv;

    assign idx_inc = idx_q + IDX_W'(1);
    assign rd_key  = mem_rd_data[KEY_W+CNT_W-1:CNT_W];
    assign rd_cnt  = mem_rd_data[CNT_W-1:0];

`ifdef RLE_PLAYER_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    // Next-state logic; fin marks the 3-cycle drain after the last entry, which reads nothing.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        fin_d       = fin_q;
        newkey_d    = newkey_q;
        key_valid_d = key_valid_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        done_d      = 1'b0;
        adv         = 1'b0;

        if (stop) begin
            state_d     = S_IDLE;
            newkey_d    = '0;
            key_valid_d = 1'b0;
            fin_d       = 1'b0;
        end else if (start) begin
            fin_d = 1'b0;
            if (num_entries == '0) begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                newkey_d    = '0;
                key_valid_d = 1'b0;
            end else begin
                num_d       = num_entries;
                idx_d       = '0;
                state_d     = S_FETCH;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = '0;
            end
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_LOAD;
                S_LOAD: begin
                    if (fin_q) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        newkey_d    = '0;
                        key_valid_d = 1'b0;
                        fin_d       = 1'b0;
                    end else if (rd_cnt != '0) begin
                        state_d     = S_PLAY;
                        newkey_d    = rd_key;
                        key_valid_d = 1'b1;
                        cnt_d       = rd_cnt;
                    end else begin
                        adv = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            adv = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // Entry boundary: next entry, wrap to 0 when looping, or drain then finish.
        if (adv) begin
            state_d = S_FETCH;
            if (idx_inc < num_q) begin
                idx_d       = idx_inc;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = idx_inc[ADDR_W-1:0];
            end else if (loop_c) begin
                idx_d       = '0;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = '0;
            end else begin
                fin_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            fin_q       <= 1'b0;
            newkey_q    <= '0;
            key_valid_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            fin_q       <= fin_d;
            newkey_q    <= newkey_d;
            key_valid_q <= key_valid_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign newkey    = newkey_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rle_key_player.sv
// Bench for rle_key_player: directed literal checks plus randomized playback compared
// every cycle against a cycle-count reference model. Loop test under RLE_PLAYER_LOOP_EN.
module tb_rle_key_player;

    localparam int unsigned AW    = 4;
    localparam int unsigned KW    = 7;
    localparam int unsigned CW    = 8;
    localparam int unsigned DW    = KW + CW;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, tick, loop_i, loop_m;
    logic [AW:0]   num_entries;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [KW-1:0] newkey;
    logic          key_valid, busy, done;

    logic [KW-1:0] ram_key [DEPTH];
    logic [CW-1:0] ram_cnt [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    int rec_key [64];
    int rec_kv  [64];
    int rec_done[64];
    int rec_rd  [64];
    int rec_addr[64];
    int rec_busy[64];

    always #5 clk = ~clk;

    rle_key_player #(.ADDR_W(AW), .KEY_W(KW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(rst),
        .start(start),
        .stop(stop),
        .num_entries(num_entries),
        .tick(tick),
`ifdef RLE_PLAYER_LOOP_EN
        .loop(loop_i),
`endif
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .newkey(newkey),
        .key_valid(key_valid),
        .busy(busy),
        .done(done)
    );

`ifdef RLE_PLAYER_LOOP_EN
    assign loop_m = loop_i;
`else
    assign loop_m = 1'b0;
`endif

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {ram_key[mem_addr], ram_cnt[mem_addr]};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: gap = cycles until the fetched entry is consumed, rem = ticks left.
    int m_active, m_gap, m_end, m_e, m_n, m_rem, m_key, m_kv, m_done, m_rd, m_addr;

    task automatic m_fetch(input int a);
        m_gap  = 3;
        m_end  = 0;
        m_rd   = 1;
        m_addr = a;
        m_e    = a;
    endtask

    task automatic m_advance();
        if (m_e + 1 < m_n) m_fetch(m_e + 1);
        else if (loop_m) m_fetch(0);
        else begin
            m_end = 1;
            m_gap = 3;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_gap = 0; m_end = 0; m_e = 0; m_n = 0; m_rem = 0;
            m_key = 0; m_kv = 0; m_done = 0; m_rd = 0; m_addr = 0;
        end else begin
            m_done = 0;
            m_rd   = 0;
            if (stop) begin
                m_active = 0; m_key = 0; m_kv = 0; m_gap = 0;
            end else if (start) begin
                if (num_entries == 0) begin
                    m_done = 1; m_active = 0; m_key = 0; m_kv = 0; m_gap = 0;
                end else begin
                    m_n = int'(num_entries);
                    m_active = 1;
                    m_fetch(0);
                end
            end else if (m_active != 0) begin
                if (m_gap > 0) begin
                    m_gap--;
                    if (m_gap == 0) begin
                        if (m_end != 0) begin
                            m_active = 0; m_done = 1; m_key = 0; m_kv = 0;
                        end else if (ram_cnt[m_e] != 0) begin
                            m_key = int'(ram_key[m_e]);
                            m_kv  = 1;
                            m_rem = int'(ram_cnt[m_e]);
                        end else begin
                            m_advance();
                        end
                    end
                end else if (tick) begin
                    m_rem--;
                    if (m_rem == 0) m_advance();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("newkey",    int'(newkey),    m_key);
            chk("key_valid", int'(key_valid), m_kv);
            chk("busy",      int'(busy),      m_active);
            chk("done",      int'(done),      m_done);
            chk("mem_rd_en", int'(mem_rd_en), m_rd);
            chk("mem_addr",  int'(mem_addr),  m_addr);
        end
    end

    // Start at cycle 0, record cycles 1..ncyc; optional stop (and start) during stop_at.
    task automatic play(input int ne, input int ncyc, input int stop_at, input logic start_too);
        @(negedge clk);
        num_entries = (AW+1)'(ne);
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == stop_at) begin
                stop  = 1'b1;
                start = start_too;
            end else if (k == stop_at + 1) begin
                stop  = 1'b0;
                start = 1'b0;
            end
            rec_key[k]  = int'(newkey);
            rec_kv[k]   = int'(key_valid);
            rec_done[k] = int'(done);
            rec_rd[k]   = int'(mem_rd_en);
            rec_addr[k] = int'(mem_addr);
            rec_busy[k] = int'(busy);
        end
    endtask

    task automatic load_ab();
        ram_key[0] = 7'h41; ram_cnt[0] = 8'd3;
        ram_key[1] = 7'h42; ram_cnt[1] = 8'd2;
    endtask

    initial begin
        int ne;
        rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; loop_i = 1'b0;
        num_entries = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram_key[i] = '0;
            ram_cnt[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_newkey", int'(newkey), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_en", int'(mem_rd_en), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick = 1'b1;

        // Two entries, tick held high
        load_ab();
        play(2, 17, 0, 1'b0);
        chk("t1_fetch_rd", rec_rd[1], 1);
        chk("t1_fetch_addr", rec_addr[1], 0);
        chk("t1_wait_rd", rec_rd[2], 0);
        chk("t1_load_kv", rec_kv[3], 0);
        chk("t1_key_c4", rec_key[4], 'h41);
        chk("t1_key_c9", rec_key[9], 'h41);
        chk("t1_addr_c7", rec_addr[7], 1);
        chk("t1_key_c10", rec_key[10], 'h42);
        chk("t1_key_c14", rec_key[14], 'h42);
        chk("t1_done_c14", rec_done[14], 0);
        chk("t1_done_c15", rec_done[15], 1);
        chk("t1_key_c15", rec_key[15], 0);
        chk("t1_kv_c15", rec_kv[15], 0);
        chk("t1_busy_c15", rec_busy[15], 0);
        chk("t1_done_c16", rec_done[16], 0);

        // Zero-count entry is skipped
        ram_key[0] = 7'h43; ram_cnt[0] = 8'd0;
        ram_key[1] = 7'h44; ram_cnt[1] = 8'd1;
        play(2, 12, 0, 1'b0);
        chk("t2_kv_c6", rec_kv[6], 0);
        chk("t2_key_c6", rec_key[6], 0);
        chk("t2_key_c7", rec_key[7], 'h44);
        chk("t2_kv_c7", rec_kv[7], 1);
        chk("t2_done_c11", rec_done[11], 1);

        // Empty recording
        play(0, 3, 0, 1'b0);
        chk("t3_done_c1", rec_done[1], 1);
        chk("t3_busy_c1", rec_busy[1], 0);
        chk("t3_rd_c1", rec_rd[1], 0);
        chk("t3_rd_c2", rec_rd[2], 0);
        chk("t3_done_c2", rec_done[2], 0);

        // Stop mid-play, alone and together with start
        load_ab();
        for (int s = 0; s < 2; s++) begin
            play(2, 8, 5, s[0]);
            chk("t4_key_c5", rec_key[5], 'h41);
            chk("t4_key_c6", rec_key[6], 0);
            chk("t4_kv_c6", rec_kv[6], 0);
            chk("t4_busy_c6", rec_busy[6], 0);
            chk("t4_done_c6", rec_done[6], 0);
            chk("t4_rd_c7", rec_rd[7], 0);
        end

        // Asynchronous reset in the WAIT of entry 1
        play(2, 8, 0, 1'b0);
        chk("t5_key_before", rec_key[8], 'h41);
        #2 rst = 1'b1;
        #1;
        chk("t5_newkey", int'(newkey), 0);
        chk("t5_kv", int'(key_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_addr", int'(mem_addr), 0);
        chk("t5_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RLE_PLAYER_LOOP_EN
        // Single looping entry
        ram_key[0] = 7'h45; ram_cnt[0] = 8'd2;
        loop_i = 1'b1;
        play(1, 20, 0, 1'b0);
        for (int k = 1; k <= 16; k += 5) begin
            chk("t6_refetch", rec_rd[k], 1);
            chk("t6_refetch_addr", rec_addr[k], 0);
        end
        for (int k = 4; k <= 20; k++) begin
            chk("t6_key", rec_key[k], 'h45);
            chk("t6_done", rec_done[k], 0);
        end
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0; loop_i = 1'b0;
`endif

        // Randomized playback against the model
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ram_key[i] = KW'($urandom_range(1, 127));
                ram_cnt[i] = CW'($urandom_range(0, 4));
            end
            ne = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(1, 16));
            if (it % 5 == 0) ne = 16;
            loop_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            num_entries = (AW+1)'(ne);
            start = 1'b1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                start = 1'b0;
                stop  = 1'b0;
                tick  = ($urandom_range(0, 3) != 0);
                if (!busy && c > 0) break;
                if ($urandom_range(0, 299) == 0) stop = 1'b1;
                else if ($urandom_range(0, 199) == 0) begin
                    num_entries = (AW+1)'($urandom_range(1, 16));
                    start = 1'b1;
                end
            end
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            loop_i = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
